// File: rtl/shift_counter_pkg.sv
// Shared definitions for the shift_counter_gen block.
// Holds the run-time mode encodings and the matching enum type.
// Used by shift_counter_next (step/illegal logic) and shift_counter_gen (top).
// Optional feature macro: SHIFT_COUNTER_SELF_CORRECT_EN (used in the top).
package shift_counter_pkg;

  localparam logic [1:0] MODE_RING_ENC    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON_ENC = 2'b01;
  localparam logic [1:0] MODE_LFSR_ENC    = 2'b10;
  localparam logic [1:0] MODE_HOLD_ENC    = 2'b11;

  typedef enum logic [1:0] {
    MODE_RING    = MODE_RING_ENC,
    MODE_JOHNSON = MODE_JOHNSON_ENC,
    MODE_LFSR    = MODE_LFSR_ENC,
    MODE_HOLD    = MODE_HOLD_ENC
  } mode_t;

endpackage

// File: rtl/shift_counter_next.sv
// Combinational next-step and legality logic for shift_counter_gen.
// Ports:
//   q        in  WIDTH  current counter state
//   mode     in  2      00 ring, 01 Johnson, 10 LFSR, 11 hold
//   dir      in  1      0 = shift toward MSB, 1 = toward LSB (ring/Johnson)
//   step_val out WIDTH  value q would take on a normal step
//   illegal  out 1      q is not a legal state for the current mode
module shift_counter_next
  import shift_counter_pkg::*;
#(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1100
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] step_val,
  output logic             illegal
);

  mode_t mode_sel;
  assign mode_sel = mode_t'(mode);

  // Neighbour differences; a legal Johnson state has at most one boundary
  // between its run of ones and its run of zeros.
  logic [WIDTH-2:0] edge_diff;
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_edge
      assign edge_diff[gi] = q[gi] ^ q[gi+1];
    end
  endgenerate

  logic lfsr_fb;
  assign lfsr_fb = ^(q & TAPS);

  always_comb begin
    step_val = q;
    illegal  = 1'b0;
    case (mode_sel)
      MODE_RING: begin
        step_val = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
        illegal  = ($countones(q) != 1);
      end
      MODE_JOHNSON: begin
        step_val = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
        illegal  = ($countones(edge_diff) > 1);
      end
      MODE_LFSR: begin
        // Direction has no meaning for the LFSR; always shifts toward MSB.
        step_val = {q[WIDTH-2:0], lfsr_fb};
        illegal  = (q == '0);
      end
      default: begin
        step_val = q;
        illegal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_counter_gen.sv
// Parametrised shift-register counter: one-hot ring, Johnson or Fibonacci
// LFSR selected at run time, with load, direction, wrap pulse and
// illegal-state reporting.
// Optional feature macro: SHIFT_COUNTER_SELF_CORRECT_EN -- when defined, an
// enabled step taken from an illegal state jumps to the mode's recovery value.
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset (q <= RESET_VAL)
//   en       in  1      advance one step this cycle
//   mode     in  2      00 ring, 01 Johnson, 10 LFSR, 11 hold
//   dir      in  1      0 = toward MSB, 1 = toward LSB (ignored for LFSR)
//   load     in  1      parallel load request (beats en)
//   load_val in  WIDTH  value to load
//   q        out WIDTH  registered counter state
//   wrap     out 1      registered pulse: a step landed on RESET_VAL
//   illegal  out 1      combinational: q illegal for current mode
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS      = 4'b1100,
  parameter logic [WIDTH-1:0] RESET_VAL = 4'b0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             illegal
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] stepped_val;
  logic             step;
  logic             recover;

  shift_counter_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .q        (q_reg),
    .mode     (mode),
    .dir      (dir),
    .step_val (step_val),
    .illegal  (illegal)
  );

  assign step = en && (mode != MODE_HOLD_ENC);

`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
  logic [WIDTH-1:0] recovery_val;
  // Johnson recovers to all zeros (start of its cycle); ring and LFSR
  // recover to the lowest one-hot value, which is legal for both.
  assign recovery_val = (mode == MODE_JOHNSON_ENC) ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
  assign recover      = step && illegal;
  assign stepped_val  = recover ? recovery_val : step_val;
`else
  assign recover      = 1'b0;
  assign stepped_val  = step_val;
`endif

  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (step) begin
      q_next = stepped_val;
      // A forced recovery is not a completed cycle, so it never wraps.
      wrap_next = !recover && (stepped_val == RESET_VAL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg    <= RESET_VAL;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

  assign q    = q_reg;
  assign wrap = wrap_reg;

endmodule

// File: doc/shift_counter_gen.md
Name: shift_counter_gen

Overview:
- Parametrised shift-register counter that generalises the fixed 4-bit D-flip-flop ring/feedback chain into one block.
- Three run-time modes: one-hot ring, Johnson (twisted ring) and Fibonacci LFSR.
- Supports enable, parallel load, shift direction, illegal-state detection and a wrap pulse.
- Used as a sequence/phase generator and pseudo-random source in the counters library.

Parameters:
- WIDTH, 4: number of stages, minimum 2.
- TAPS, 4'b1100: LFSR feedback mask, WIDTH bits; bit i set means q[i] feeds the XOR. The default implements x^4+x^3+1, which is maximal length.
- RESET_VAL, 4'b0001: value loaded by reset, WIDTH bits; also the wrap reference.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  advance one step this cycle.
- mode  in  2  00 ring, 01 Johnson, 10 LFSR, 11 hold.
- dir  in  1  0 = shift toward MSB (q[i] <= q[i-1]); 1 = shift toward LSB. Ignored in LFSR mode.
- load  in  1  parallel load request.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  counter state (registered).
- wrap  out  1  registered one-cycle pulse.
- illegal  out  1  combinational: q is not a legal state for the current mode.

Behaviour:
- Priority at each rising clk edge: rst > load > en. With none of them active, q holds.
- Reset: q <= RESET_VAL, wrap <= 0. Reset mid-sequence is honoured on that same edge.
- Load: q <= load_val, wrap <= 0. Load works regardless of en and does not count as a step.
- Step (en=1, mode != 11), dir=0:
  - Ring: q <= {q[W-2:0], q[W-1]}.
  - Johnson: q <= {q[W-2:0], ~q[W-1]}.
  - LFSR: q <= {q[W-2:0], ^(q & TAPS)}.
- Step with dir=1 (ring and Johnson only):
  - Ring: q <= {q[0], q[W-1:1]}.
  - Johnson: q <= {~q[0], q[W-1:1]}.
- mode=11: q holds even when en=1; illegal=0.
- A mode or dir change takes effect on the next edge; the current q carries over unchanged.
- Latency: q reflects a step one clk after en is sampled.
- wrap <= 1 exactly when a step (not reset, not load) makes next q == RESET_VAL; otherwise wrap <= 0.
- illegal, per mode:
  - Ring: popcount(q) != 1.
  - Johnson: more than one index i in 0..W-2 with q[i] != q[i+1].
  - LFSR: q == 0.
  - Hold: 0.
- illegal is evaluated continuously, including after a load of a bad value.
- Boundaries:
  - Ring with an all-zero q shifts zeros forever unless corrected (see Optional Feature).
  - LFSR at zero stays at zero unless corrected.
  - Johnson always rotates through 2*W states when legal.

Optional Feature:
- Macro SHIFT_COUNTER_SELF_CORRECT_EN.
- When defined, an enabled step taken while illegal=1 forces the next q to the mode's recovery value instead of the normal shift:
  - Ring: {{W-1{0}},1}.
  - Johnson: all zeros.
  - LFSR: {{W-1{0}},1}.
- A recovery step never asserts wrap, even when the recovery value equals RESET_VAL.
- When undefined, illegal is still reported but stepping applies the normal shift rules unchanged.

Decomposition:
- Package shift_counter_pkg holds:
  - the mode typedef (MODE_RING, MODE_JOHNSON, MODE_LFSR, MODE_HOLD);
  - the localparam encodings of those modes.
- Sub-module shift_counter_next: purely combinational; inputs q, mode, dir; outputs the next-step value and illegal.
- Top level holds the register, the rst/load/en priority, wrap generation and the self-correct mux.

Test Plan:
- Ring, W=4, reset then en=1, dir=0: q = 0001, 0010, 0100, 1000, 0001; wrap high only with the 5th value. With dir=1: 0001, 1000, 0100, 0010, 0001.
- Johnson from 0001, dir=0: 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; wrap high on the 8th step only.
- LFSR, TAPS=1100, seed 0001: 0010, 0100, 1001, 0011, 0110, 1101, ... Returns to 0001 after exactly 15 steps; all 15 values are distinct and nonzero; wrap high once.
- Priority: rst=1, load=1, en=1 on one edge gives q=0001. Next cycle load=1, load_val=1010, en=1 gives q=1010, wrap=0. en=0 for 3 cycles: q holds 1010.
- Illegal state: load 0000 in LFSR mode gives illegal=1. Then en=1:
  - with SHIFT_COUNTER_SELF_CORRECT_EN, q=0001 next, illegal=0, wrap=0;
  - without it, q stays 0000 and illegal stays 1.
- Mode switch mid-run: ring at 0100, set mode=01 and en=1, giving q=1001 (Johnson step), illegal=1. Switching to mode=11 freezes q with illegal=0.
